// File: rtl/html_pkg.sv
// Shared definitions for the HTML tokenizer: character codes, token/tag/attr ids
// and the first-letter/length signatures used to recognise names.
package html_pkg;

    localparam int CHAR_BITS = 8;

    typedef enum logic [2:0] {
        TOK_NONE      = 3'd0,
        TOK_TAG_OPEN  = 3'd1,
        TOK_TAG_CLOSE = 3'd2,
        TOK_ATTR      = 3'd3,
        TOK_TEXT      = 3'd4,
        TOK_END       = 3'd5,
        TOK_ERROR     = 3'd6
    } token_type_t;

    typedef enum logic [1:0] {
        TAG_UNKNOWN = 2'd0,
        TAG_BODY    = 2'd1,
        TAG_P       = 2'd2
    } tag_id_t;

    typedef enum logic [1:0] {
        ATTR_UNKNOWN    = 2'd0,
        ATTR_BACKGROUND = 2'd1,
        ATTR_COLOR      = 2'd2,
        ATTR_SIZE       = 2'd3
    } attr_id_t;

    localparam logic [CHAR_BITS-1:0] CH_LT    = 8'h3C;
    localparam logic [CHAR_BITS-1:0] CH_GT    = 8'h3E;
    localparam logic [CHAR_BITS-1:0] CH_SLASH = 8'h2F;
    localparam logic [CHAR_BITS-1:0] CH_EQ    = 8'h3D;
    localparam logic [CHAR_BITS-1:0] CH_SPACE = 8'h20;
    localparam logic [CHAR_BITS-1:0] CH_NUL   = 8'h00;

    // Names are recognised only by first letter and (saturated) length.
    localparam logic [CHAR_BITS-1:0] TAG_BODY_CH  = "b";
    localparam int                   TAG_BODY_LEN = 4;
    localparam logic [CHAR_BITS-1:0] TAG_P_CH     = "p";
    localparam int                   TAG_P_LEN    = 1;

    localparam logic [CHAR_BITS-1:0] ATTR_BACKGROUND_CH  = "b";
    localparam int                   ATTR_BACKGROUND_LEN = 10;
    localparam logic [CHAR_BITS-1:0] ATTR_COLOR_CH       = "c";
    localparam int                   ATTR_COLOR_LEN      = 5;
    localparam logic [CHAR_BITS-1:0] ATTR_SIZE_CH        = "s";
    localparam int                   ATTR_SIZE_LEN       = 4;

    function automatic logic is_letter(input logic [CHAR_BITS-1:0] c);
        return (c >= "a" && c <= "z") || (c >= "A" && c <= "Z");
    endfunction

    function automatic logic is_digit(input logic [CHAR_BITS-1:0] c);
        return (c >= "0" && c <= "9");
    endfunction

endpackage

// File: rtl/char_skid.sv
// One-deep character skid buffer: passes chars straight through and holds one
// char when the consumer is not ready, draining it before any new input.
module char_skid
    import html_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [CHAR_BITS-1:0] in_data,
    output logic                 out_valid,
    output logic [CHAR_BITS-1:0] out_data,
    input  logic                 out_ready,
    output logic                 full
);

    logic [CHAR_BITS-1:0] held;

    assign out_valid = full | in_valid;
    assign out_data  = full ? held : in_data;

    always_ff @(posedge clock) begin
        if (reset) begin
            full <= 1'b0;
        end else if (!full) begin
            full <= in_valid & ~out_ready;
        end else if (out_ready) begin
            full <= in_valid;
        end
    end

    // Held char is only meaningful while full, so it carries no reset.
    always_ff @(posedge clock) begin
        if (in_valid && (full ? out_ready : !out_ready)) begin
            held <= in_data;
        end
    end

endmodule

// File: rtl/html_tokenizer.sv
// Character-stream to token converter between the reader and the layout stage.
// Optional build macro HTML_TOKENIZER_CASEFOLD_EN folds A-Z in tag/attr names.
module html_tokenizer
    import html_pkg::*;
#(
    parameter int NAME_LEN_BITS = 4
)
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 state_enable,
    input  logic [CHAR_BITS-1:0] char,
    input  logic                 reader_finished,
    output logic                 pause,
    output logic                 token_valid,
    input  logic                 token_ready,
    output logic [2:0]           token_type,
    output logic [1:0]           token_tag,
    output logic [1:0]           token_attr,
    output logic [7:0]           token_value,
    output logic                 has_finished
);

    localparam logic [2:0] S_TEXT       = 3'd0;
    localparam logic [2:0] S_TAG_START  = 3'd1;
    localparam logic [2:0] S_TAG_NAME   = 3'd2;
    localparam logic [2:0] S_CLOSE_NAME = 3'd3;
    localparam logic [2:0] S_ATTR_WAIT  = 3'd4;
    localparam logic [2:0] S_ATTR_NAME  = 3'd5;
    localparam logic [2:0] S_ATTR_VALUE = 3'd6;
    localparam logic [2:0] S_DONE       = 3'd7;

    logic                     clear;
    logic                     in_valid;
    logic                     sk_valid;
    logic [CHAR_BITS-1:0]     sk_data;
    logic                     skid_full;
    logic                     take;
    logic                     out_free;

    logic [2:0]               state_q, state_d;
    logic                     pend_end_q, pend_d;
    logic [CHAR_BITS-1:0]     name_first, first_d;
    logic [NAME_LEN_BITS-1:0] name_len, len_d;
    logic [7:0]               attr_value, value_d;

    logic                     gen, blocked, err;
    token_type_t              g_type;
    tag_id_t                  g_tag;
    attr_id_t                 g_attr;
    logic [7:0]               g_value;
    logic [CHAR_BITS-1:0]     lc;

    function automatic logic [CHAR_BITS-1:0] fold_case(input logic [CHAR_BITS-1:0] c);
`ifdef HTML_TOKENIZER_CASEFOLD_EN
        if (c >= "A" && c <= "Z") return c | 8'h20;
`endif
        return c;
    endfunction

    function automatic logic [NAME_LEN_BITS-1:0] len_sat_inc(input logic [NAME_LEN_BITS-1:0] n);
        return (n == '1) ? n : n + 1'b1;
    endfunction

    function automatic logic [7:0] value_sat_mac(input logic [7:0] v, input logic [CHAR_BITS-1:0] c);
        logic [11:0] acc;
        acc = 12'(v) * 12'd10 + 12'(c - 8'h30);
        return (acc > 12'd255) ? 8'd255 : acc[7:0];
    endfunction

    function automatic tag_id_t tag_lookup(input logic [CHAR_BITS-1:0] f, input logic [NAME_LEN_BITS-1:0] n);
        if (f == TAG_BODY_CH && 32'(n) == TAG_BODY_LEN) return TAG_BODY;
        if (f == TAG_P_CH && 32'(n) == TAG_P_LEN) return TAG_P;
        return TAG_UNKNOWN;
    endfunction

    function automatic attr_id_t attr_lookup(input logic [CHAR_BITS-1:0] f, input logic [NAME_LEN_BITS-1:0] n);
        if (f == ATTR_BACKGROUND_CH && 32'(n) == ATTR_BACKGROUND_LEN) return ATTR_BACKGROUND;
        if (f == ATTR_COLOR_CH && 32'(n) == ATTR_COLOR_LEN) return ATTR_COLOR;
        if (f == ATTR_SIZE_CH && 32'(n) == ATTR_SIZE_LEN) return ATTR_SIZE;
        return ATTR_UNKNOWN;
    endfunction

    assign clear    = reset | ~state_enable;
    assign out_free = ~token_valid | token_ready;
    assign pause    = (token_valid & ~token_ready) | skid_full | (state_q == S_DONE);

    char_skid u_skid (
        .clock     (clock),
        .reset     (clear),
        .in_valid  (in_valid),
        .in_data   (char),
        .out_valid (sk_valid),
        .out_data  (sk_data),
        .out_ready (take),
        .full      (skid_full)
    );

    always_comb begin
        state_d = state_q;
        pend_d  = pend_end_q;
        first_d = name_first;
        len_d   = name_len;
        value_d = attr_value;
        gen     = 1'b0;
        err     = 1'b0;
        g_type  = TOK_NONE;
        g_tag   = TAG_UNKNOWN;
        g_attr  = ATTR_UNKNOWN;
        g_value = 8'd0;
        lc      = fold_case(sk_data);

        if (state_q == S_DONE) begin
            if (pend_end_q) begin
                gen    = 1'b1;
                g_type = TOK_END;
                pend_d = 1'b0;
            end
        end else if (sk_valid) begin
            if (sk_data == CH_NUL) begin
                // NUL outside plain text is a truncated construct: ERROR now, END queued.
                gen     = 1'b1;
                state_d = S_DONE;
                if (state_q == S_TEXT) begin
                    g_type = TOK_END;
                end else begin
                    g_type = TOK_ERROR;
                    pend_d = 1'b1;
                end
            end else begin
                case (state_q)
                    S_TEXT: begin
                        if (sk_data == CH_LT) begin
                            state_d = S_TAG_START;
                        end else begin
                            gen     = 1'b1;
                            g_type  = TOK_TEXT;
                            g_value = sk_data;
                        end
                    end
                    S_TAG_START: begin
                        if (sk_data == CH_SLASH) begin
                            state_d = S_CLOSE_NAME;
                            first_d = '0;
                            len_d   = '0;
                        end else if (is_letter(sk_data)) begin
                            state_d = S_TAG_NAME;
                            first_d = lc;
                            len_d   = NAME_LEN_BITS'(1);
                        end else begin
                            err = 1'b1;
                        end
                    end
                    S_TAG_NAME, S_CLOSE_NAME: begin
                        if (is_letter(sk_data)) begin
                            if (name_len == '0) first_d = lc;
                            len_d = len_sat_inc(name_len);
                        end else if (sk_data == CH_GT ||
                                     (sk_data == CH_SPACE && state_q == S_TAG_NAME)) begin
                            gen     = 1'b1;
                            g_type  = (state_q == S_TAG_NAME) ? TOK_TAG_OPEN : TOK_TAG_CLOSE;
                            g_tag   = tag_lookup(name_first, name_len);
                            state_d = (sk_data == CH_SPACE) ? S_ATTR_WAIT : S_TEXT;
                        end else begin
                            err = 1'b1;
                        end
                    end
                    S_ATTR_WAIT: begin
                        if (is_letter(sk_data)) begin
                            state_d = S_ATTR_NAME;
                            first_d = lc;
                            len_d   = NAME_LEN_BITS'(1);
                        end else if (sk_data == CH_GT) begin
                            state_d = S_TEXT;
                        end else if (sk_data != CH_SPACE) begin
                            err = 1'b1;
                        end
                    end
                    S_ATTR_NAME: begin
                        if (is_letter(sk_data)) begin
                            len_d = len_sat_inc(name_len);
                        end else if (sk_data == CH_EQ) begin
                            state_d = S_ATTR_VALUE;
                            value_d = 8'd0;
                        end else begin
                            err = 1'b1;
                        end
                    end
                    S_ATTR_VALUE: begin
                        if (is_digit(sk_data)) begin
                            value_d = value_sat_mac(attr_value, sk_data);
                        end else if (sk_data == CH_SPACE || sk_data == CH_GT) begin
                            gen     = 1'b1;
                            g_type  = TOK_ATTR;
                            g_attr  = attr_lookup(name_first, name_len);
                            g_value = attr_value;
                            state_d = (sk_data == CH_SPACE) ? S_ATTR_WAIT : S_TEXT;
                        end else begin
                            err = 1'b1;
                        end
                    end
                    default: err = 1'b1;
                endcase
                if (err) begin
                    gen     = 1'b1;
                    g_type  = TOK_ERROR;
                    state_d = S_TEXT;
                end
            end
        end else if (reader_finished) begin
            gen     = 1'b1;
            g_type  = TOK_END;
            state_d = S_DONE;
        end

        // A char that would produce a token waits while the output slot is occupied.
        blocked = gen & ~out_free;
        if (blocked) begin
            state_d = state_q;
            pend_d  = pend_end_q;
            first_d = name_first;
            len_d   = name_len;
            value_d = attr_value;
            gen     = 1'b0;
        end
        take = (state_q == S_DONE) | (sk_valid & ~blocked);
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            in_valid     <= 1'b0;
            state_q      <= S_TEXT;
            pend_end_q   <= 1'b0;
            token_valid  <= 1'b0;
            token_type   <= 3'd0;
            token_tag    <= 2'd0;
            token_attr   <= 2'd0;
            token_value  <= 8'd0;
            has_finished <= 1'b0;
        end else begin
            in_valid   <= ~pause & ~reader_finished;
            state_q    <= state_d;
            pend_end_q <= pend_d;
            if (gen) begin
                token_valid <= 1'b1;
                token_type  <= g_type;
                token_tag   <= g_tag;
                token_attr  <= g_attr;
                token_value <= g_value;
            end else if (token_ready) begin
                token_valid <= 1'b0;
            end
            if (token_valid && token_ready && token_type == TOK_END) begin
                has_finished <= 1'b1;
            end
        end
    end

    // Name and value accumulators are re-seeded before use, so they carry no reset.
    always_ff @(posedge clock) begin
        name_first <= first_d;
        name_len   <= len_d;
        attr_value <= value_d;
    end

endmodule

// File: tb/tb_html_tokenizer.sv
// Directed bench for html_tokenizer: streams strings ('~' stands for NUL) and
// compares accepted tokens against hand-derived sequences.
module tb_html_tokenizer;

    logic       clock;
    logic       reset;
    logic       state_enable;
    logic [7:0] char;
    logic       reader_finished;
    logic       pause;
    logic       token_valid;
    logic       token_ready;
    logic [2:0] token_type;
    logic [1:0] token_tag;
    logic [1:0] token_attr;
    logic [7:0] token_value;
    logic       has_finished;

    int total;
    int bad;
    logic [14:0] exp_q[$];

    html_tokenizer dut (
        .clock           (clock),
        .reset           (reset),
        .state_enable    (state_enable),
        .char            (char),
        .reader_finished (reader_finished),
        .pause           (pause),
        .token_valid     (token_valid),
        .token_ready     (token_ready),
        .token_type      (token_type),
        .token_tag       (token_tag),
        .token_attr      (token_attr),
        .token_value     (token_value),
        .has_finished    (has_finished)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [14:0] tk(input int ty, input int tg, input int at, input int v);
        return {3'(ty), 2'(tg), 2'(at), 8'(v)};
    endfunction

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        state_enable = 1'b1;
        token_ready = 1'b0;
        char = 8'h00;
        reader_finished = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    // mode 0: always ready, 1: ready one cycle in three, 2: never ready
    task automatic run(input string s, input int mode, input int maxc, input bit until_empty);
        int idx;
        int cyc;
        bit adv;
        logic [14:0] got;
        idx = 0;
        cyc = 0;
        while (cyc < maxc && (!until_empty || exp_q.size() > 0)) begin
            @(negedge clock);
            token_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'b0;
            #1;
            if (token_valid && !token_ready) check("pause_on_stall", pause, 1);
            if (token_valid && token_ready) begin
                got = {token_type, token_tag, token_attr, token_value};
                if (exp_q.size() == 0) check("extra_token", got, 0);
                else check("token", got, exp_q.pop_front());
            end
            adv = !pause && !reader_finished;
            @(posedge clock);
            #1;
            if (adv && idx < s.len()) begin
                char = (s[idx] == "~") ? 8'h00 : s[idx];
                idx++;
                reader_finished = (idx == s.len());
            end
            cyc++;
        end
        if (until_empty) check("tokens_left", exp_q.size(), 0);
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b1;
        state_enable = 1'b1;
        token_ready = 1'b0;
        char = 8'h00;
        reader_finished = 1'b0;

        do_reset();
        check("rst_valid", token_valid, 0);
        check("rst_type", token_type, 0);
        check("rst_value", token_value, 0);
        check("rst_pause", pause, 0);
        check("rst_fin", has_finished, 0);

        for (int mode = 0; mode < 2; mode++) begin
            do_reset();
            exp_q = '{tk(1,1,0,0), tk(3,0,1,3), tk(1,2,0,0), tk(3,0,2,1), tk(3,0,3,2),
                      tk(4,0,0,"t"), tk(4,0,0,"e"), tk(4,0,0,"s"), tk(4,0,0,"t"),
                      tk(2,2,0,0), tk(2,1,0,0), tk(5,0,0,0)};
            run("<body background=3><p color=1 size=2>test</p></body>~", mode, 800, 1'b1);
            check("canon_fin", has_finished, 1);
        end

        do_reset();
        exp_q = '{tk(1,2,0,0), tk(3,0,3,255), tk(5,0,0,0)};
        run("<p size=300>~", 0, 200, 1'b1);
        check("sat_fin", has_finished, 1);

        do_reset();
        exp_q = '{tk(1,2,0,0), tk(3,0,3,12), tk(5,0,0,0)};
        run("<p size=12>~", 1, 300, 1'b1);

        do_reset();
        exp_q = '{tk(1,2,0,0), tk(6,0,0,0), tk(4,0,0,"1"), tk(4,0,0,">"),
                  tk(4,0,0,"x"), tk(5,0,0,0)};
        run("<p =1>x~", 0, 200, 1'b1);

        do_reset();
        exp_q = '{tk(6,0,0,0), tk(5,0,0,0)};
        run("<p~", 0, 100, 1'b1);
        check("trunc_fin", has_finished, 1);

        do_reset();
        exp_q = '{tk(4,0,0,"a"), tk(4,0,0,"b"), tk(4,0,0,"c"), tk(5,0,0,0)};
        run("abc", 0, 100, 1'b1);

        do_reset();
`ifdef HTML_TOKENIZER_CASEFOLD_EN
        exp_q = '{tk(1,1,0,0), tk(5,0,0,0)};
`else
        exp_q = '{tk(1,0,0,0), tk(5,0,0,0)};
`endif
        run("<BODY>~", 0, 100, 1'b1);

        do_reset();
        run("<p size=1", 2, 12, 1'b0);
        check("stall_valid", token_valid, 1);
        check("stall_pause", pause, 1);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("mid_rst_valid", token_valid, 0);
        check("mid_rst_type", token_type, 0);
        check("mid_rst_tag", token_tag, 0);
        check("mid_rst_pause", pause, 0);
        reset = 1'b0;
        reader_finished = 1'b0;
        exp_q = '{tk(1,2,0,0), tk(3,0,3,12), tk(4,0,0,"x"), tk(5,0,0,0)};
        run("<p size=12>x~", 0, 200, 1'b1);
        check("restart_fin", has_finished, 1);

        do_reset();
        run("ab", 2, 6, 1'b0);
        check("en_stall_valid", token_valid, 1);
        @(negedge clock);
        state_enable = 1'b0;
        @(posedge clock);
        #1;
        check("dis_valid", token_valid, 0);
        check("dis_value", token_value, 0);
        check("dis_fin", has_finished, 0);
        state_enable = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
